// File: rtl/ws2812_frame_sched_pkg.sv
// Shared types and constants for the ws2812 frame scheduler and its pixel banks.
package ws2812_frame_sched_pkg;

   localparam int unsigned NUM_PIX_DEF  = 64;
   localparam int unsigned BITS_PER_PIX = 24;
   localparam int unsigned CH_W         = 8;
   localparam int unsigned CNT_BIT_W    = 5;
   localparam int unsigned CNT_PIX_W    = 7;
   localparam int unsigned WR_ADDR_W    = 7;
   localparam int unsigned BRIGHT_W     = 3;

   // Pixel word in wire order: G is shifted out first, B last.
   typedef struct packed {
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] b;
   } grb_t;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_PENDING = 3'd2,
      ST_SWAP    = 3'd3,
      ST_CLEAR   = 3'd4
   } state_t;

   // Reorder a {R,G,B} write word into the stored GRB layout.
   function automatic grb_t rgb_to_grb(input logic [BITS_PER_PIX-1:0] rgb);
      grb_t p;
      p.r = rgb[23:16];
      p.g = rgb[15:8];
      p.b = rgb[7:0];
      return p;
   endfunction

   // Per-channel zero-filled right shift; no rounding.
   function automatic grb_t scale_grb(input grb_t p, input logic [BRIGHT_W-1:0] sh);
      grb_t s;
      s.g = p.g >> sh;
      s.r = p.r >> sh;
      s.b = p.b >> sh;
      return s;
   endfunction

endpackage

// File: rtl/ws2812_frame_sched_if.sv
// Pixel write / commit bus between draw logic (master) and the frame scheduler (slave).
interface ws2812_frame_sched_if
   import ws2812_frame_sched_pkg::*;
();
   logic                    wr_en;
   logic [WR_ADDR_W-1:0]    wr_addr;
   logic [BITS_PER_PIX-1:0] wr_rgb;
   logic                    commit;
   logic                    wr_ready;

   modport master (output wr_en, output wr_addr, output wr_rgb, output commit, input wr_ready);
   modport slave  (input wr_en, input wr_addr, input wr_rgb, input commit, output wr_ready);
endinterface

// File: rtl/ws2812_frame_sched_pix_bank.sv
// One pixel bank: synchronous write, asynchronous read, synchronous clear port.
module ws2812_frame_sched_pix_bank
   import ws2812_frame_sched_pkg::*;
#(
   parameter int unsigned DEPTH  = NUM_PIX_DEF,
   parameter int unsigned ADDR_W = 6
)(
   input  logic              sys_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  grb_t              i_wdata,
   input  logic              i_clr,
   input  logic [ADDR_W-1:0] i_caddr,
   input  logic [ADDR_W-1:0] i_raddr,
   output grb_t              o_rdata_c
);

   grb_t r_mem [DEPTH];

   // Clear has priority; the scheduler never requests both in one cycle.
   always_ff @(posedge sys_clk) begin
      if (i_clr) begin
         r_mem[i_caddr] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/ws2812_frame_sched.sv
// Double-buffered frame store with boundary-synchronised bank swap and brightness-scaled bit serving.
module ws2812_frame_sched
   import ws2812_frame_sched_pkg::*;
#(
   parameter int unsigned NUM_PIX       = NUM_PIX_DEF,
   parameter bit          CLEAR_ON_SWAP = 1'b1
)(
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   ws2812_frame_sched_if.slave  wr_if,
   input  logic [BRIGHT_W-1:0]  i_bright,
   input  logic [CNT_BIT_W-1:0] i_cnt_bit,
   input  logic [CNT_PIX_W-1:0] i_cnt_pixel,
   output logic                 o_bit_c,
   output logic                 o_frame_done,
   output logic                 o_swap_done
);

   localparam int unsigned ADDR_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

   state_t                 r_state;
   logic                   r_front_sel;
   logic [ADDR_W-1:0]      r_clr_addr;
   logic [CNT_PIX_W-1:0]   r_prev_pix;
   logic                   r_wr_ready;
   logic                   r_frame_done;
   logic                   r_swap_done;

   logic                   w_boundary;
   logic                   w_wr_ok;
   logic                   w_clr_last;
   logic                   w_back_sel;
   logic                   w_clearing;
   logic [1:0]             w_we;
   logic [1:0]             w_clr;
   logic [ADDR_W-1:0]      w_waddr;
   logic [ADDR_W-1:0]      w_raddr;
   grb_t                   w_wdata;
   grb_t                   w_rd0;
   grb_t                   w_rd1;
   grb_t                   w_front;
   grb_t                   w_scaled;
   logic [BITS_PER_PIX-1:0] w_scaled_vec;
   logic [CNT_BIT_W-1:0]   w_bit_idx;
   logic                   w_pix_ok;

   // Frame boundary: driver pixel counter wraps from the last pixel back to zero.
   assign w_boundary = (r_prev_pix == CNT_PIX_W'(NUM_PIX - 1)) && (i_cnt_pixel == '0);

   // Bank write/clear steering; the front bank is never a write or clear target after INIT.
   assign w_back_sel = ~r_front_sel;
   assign w_wr_ok    = wr_if.wr_en && (r_state == ST_IDLE) && (32'(wr_if.wr_addr) < NUM_PIX);
   assign w_clr_last = (r_clr_addr == ADDR_W'(NUM_PIX - 1));
   assign w_clearing = (r_state == ST_CLEAR);
   assign w_waddr    = ADDR_W'(wr_if.wr_addr);
   assign w_wdata    = rgb_to_grb(wr_if.wr_rgb);
   assign w_we[0]    = w_wr_ok && (w_back_sel == 1'b0);
   assign w_we[1]    = w_wr_ok && (w_back_sel == 1'b1);
   assign w_clr[0]   = (r_state == ST_INIT) || (w_clearing && (w_back_sel == 1'b0));
   assign w_clr[1]   = (r_state == ST_INIT) || (w_clearing && (w_back_sel == 1'b1));
   assign w_raddr    = ADDR_W'(i_cnt_pixel);

   ws2812_frame_sched_pix_bank #(.DEPTH(NUM_PIX), .ADDR_W(ADDR_W)) u_bank0 (
      .sys_clk   (sys_clk),
      .i_we      (w_we[0]),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_clr     (w_clr[0]),
      .i_caddr   (r_clr_addr),
      .i_raddr   (w_raddr),
      .o_rdata_c (w_rd0)
   );

   ws2812_frame_sched_pix_bank #(.DEPTH(NUM_PIX), .ADDR_W(ADDR_W)) u_bank1 (
      .sys_clk   (sys_clk),
      .i_we      (w_we[1]),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_clr     (w_clr[1]),
      .i_caddr   (r_clr_addr),
      .i_raddr   (w_raddr),
      .o_rdata_c (w_rd1)
   );

   // Zero-latency bit mux: scaled front pixel, MSB of G first; gated while banks are being zeroed.
   assign w_front      = r_front_sel ? w_rd1 : w_rd0;
   assign w_scaled     = scale_grb(w_front, i_bright);
   assign w_scaled_vec = w_scaled;
   assign w_bit_idx    = CNT_BIT_W'(BITS_PER_PIX - 1) - i_cnt_bit;
   assign w_pix_ok     = (32'(i_cnt_pixel) < NUM_PIX) && (i_cnt_bit < CNT_BIT_W'(BITS_PER_PIX));
   assign o_bit_c      = (r_state != ST_INIT) && w_pix_ok && w_scaled_vec[w_bit_idx];

   // Boundary detector: previous pixel index and registered frame_done pulse.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_prev_pix   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_prev_pix   <= i_cnt_pixel;
         r_frame_done <= w_boundary;
      end
   end

   // Scheduler FSM with clear address counter, bank select and registered handshake outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state     <= ST_INIT;
         r_front_sel <= 1'b0;
         r_clr_addr  <= '0;
         r_wr_ready  <= 1'b0;
         r_swap_done <= 1'b0;
      end else begin
         r_swap_done <= 1'b0;
         case (r_state)
            ST_INIT, ST_CLEAR: begin
               r_clr_addr <= r_clr_addr + ADDR_W'(1);
               if (w_clr_last) begin
                  r_clr_addr <= '0;
                  r_state    <= ST_IDLE;
                  r_wr_ready <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (wr_if.commit) begin
                  r_state    <= ST_PENDING;
                  r_wr_ready <= 1'b0;
               end
            end
            ST_PENDING: begin
               if (w_boundary) begin
                  r_state     <= ST_SWAP;
                  r_front_sel <= ~r_front_sel;
                  r_swap_done <= 1'b1;
               end
            end
            ST_SWAP: begin
               r_clr_addr <= '0;
               if (CLEAR_ON_SWAP) begin
                  r_state <= ST_CLEAR;
               end else begin
                  r_state    <= ST_IDLE;
                  r_wr_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_INIT;
               r_clr_addr <= '0;
               r_wr_ready <= 1'b0;
            end
         endcase
      end
   end

   assign wr_if.wr_ready = r_wr_ready;
   assign o_frame_done   = r_frame_done;
   assign o_swap_done    = r_swap_done;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Self-checking bench: one DUT with clear-on-swap, one without, driven by the same stimulus.
module tb_ws2812_frame_sched;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [6:0]  wr_addr = '0;
   logic [23:0] wr_rgb = '0;
   logic        commit = 1'b0;
   logic [2:0]  bright = '0;
   logic [4:0]  cnt_bit = '0;
   logic [6:0]  cnt_pixel = '0;
   logic        bit1, bit0, fd1, fd0, sd1, sd0;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic e1;
      logic e0;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      int          pix;
      logic [2:0]  br;
      logic [23:0] exp_grb;
   } vec_t;
   vec_t vecs[9];

   always #5 sys_clk = ~sys_clk;

   ws2812_frame_sched_if if1();
   ws2812_frame_sched_if if0();

   assign if1.wr_en = wr_en;   assign if0.wr_en = wr_en;
   assign if1.wr_addr = wr_addr; assign if0.wr_addr = wr_addr;
   assign if1.wr_rgb = wr_rgb;  assign if0.wr_rgb = wr_rgb;
   assign if1.commit = commit;  assign if0.commit = commit;

   ws2812_frame_sched #(.NUM_PIX(64), .CLEAR_ON_SWAP(1'b1)) u_dut1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_if(if1), .i_bright(bright),
      .i_cnt_bit(cnt_bit), .i_cnt_pixel(cnt_pixel), .o_bit_c(bit1),
      .o_frame_done(fd1), .o_swap_done(sd1));

   ws2812_frame_sched #(.NUM_PIX(64), .CLEAR_ON_SWAP(1'b0)) u_dut0 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_if(if0), .i_bright(bright),
      .i_cnt_bit(cnt_bit), .i_cnt_pixel(cnt_pixel), .o_bit_c(bit0),
      .o_frame_done(fd0), .o_swap_done(sd0));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic write_px(input int a, input logic [23:0] rgb);
      wr_en = 1'b1; wr_addr = 7'(a); wr_rgb = rgb;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      tick();
      commit = 1'b0;
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      while (!(if1.wr_ready === 1'b1 && if0.wr_ready === 1'b1) && cyc < 300) begin
         tick();
         cyc++;
      end
      check("ready_timeout", 32'(cyc < 300), 32'd1);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_rdy1"}, 32'(if1.wr_ready), 32'd0);
      check({tag, "_rdy0"}, 32'(if0.wr_ready), 32'd0);
      check({tag, "_fd"},   32'({fd1, fd0}), 32'd0);
      check({tag, "_sd"},   32'({sd1, sd0}), 32'd0);
   endtask

   // Sweep one driver frame (one cycle per pixel) plus a short gap, counting pulses.
   task automatic run_frame(input bit commit_at_boundary, output int n_sd1, output int n_sd0,
                            output int n_fd1, output int n_fd0, output int bad);
      n_sd1 = 0; n_sd0 = 0; n_fd1 = 0; n_fd0 = 0; bad = 0;
      for (int p = 0; p < 67; p++) begin
         cnt_pixel = (p < 64) ? 7'(p) : 7'd0;
         commit = (p == 64) && commit_at_boundary;
         @(negedge sys_clk);
         n_sd1 += int'(sd1); n_sd0 += int'(sd0);
         n_fd1 += int'(fd1); n_fd0 += int'(fd0);
         if ((sd1 && !fd1) || (sd0 && !fd0)) bad++;
         tick();
         commit = 1'b0;
      end
   endtask

   task automatic frame_checks(input string tag, input bit cab, input int exp_sd);
      int a, b, c, d, bad;
      run_frame(cab, a, b, c, d, bad);
      check({tag, "_swap1"}, 32'(a), 32'(exp_sd));
      check({tag, "_swap0"}, 32'(b), 32'(exp_sd));
      check({tag, "_fdone1"}, 32'(c), 32'd1);
      check({tag, "_fdone0"}, 32'(d), 32'd1);
      check({tag, "_swap_at_fdone"}, 32'(bad), 32'd0);
   endtask

   // Push the 24 expected bits plus an out-of-range bit index, then apply and pop.
   task automatic read_px(input int p, input logic [23:0] e1, input logic [23:0] e0);
      exp_t e;
      for (int b = 0; b < 24; b++) begin
         e.e1 = e1[23-b]; e.e0 = e0[23-b];
         sb_q.push_back(e);
      end
      e.e1 = 1'b0; e.e0 = 1'b0;
      sb_q.push_back(e);
      for (int b = 0; b < 25; b++) begin
         cnt_pixel = 7'(p);
         cnt_bit   = 5'(b);
         @(negedge sys_clk);
         e = sb_q.pop_front();
         check($sformatf("px%0d_br%0d_b%0d_d1", p, bright, b), 32'(bit1), 32'(e.e1));
         check($sformatf("px%0d_br%0d_b%0d_d0", p, bright, b), 32'(bit0), 32'(e.e0));
         tick();
      end
      cnt_bit = '0;
   endtask

   initial begin
      int cyc;
      logic acc;

      vecs[0] = '{5, 3'd0, 24'h00FF80};
      vecs[1] = '{6, 3'd0, 24'hFF0080};
      vecs[2] = '{6, 3'd1, 24'h7F0040};
      vecs[3] = '{6, 3'd7, 24'h010001};
      vecs[4] = '{7, 3'd0, 24'h341256};
      vecs[5] = '{7, 3'd2, 24'h0D0415};
      vecs[6] = '{8, 3'd3, 24'h18141C};
      vecs[7] = '{5, 3'd4, 24'h000F08};
      vecs[8] = '{0, 3'd0, 24'h000000};

      // Reset state and INIT length
      repeat (3) tick();
      check_reset_outs("rst");
      sys_rst_n = 1'b1;
      cnt_pixel = 7'd5; cnt_bit = 5'd8;
      #1;
      check("init_bit1", 32'(bit1), 32'd0);
      check("init_bit0", 32'(bit0), 32'd0);
      cyc = 0;
      while (if1.wr_ready !== 1'b1 && cyc < 300) begin
         tick();
         cyc++;
      end
      check("init_cycles", 32'(cyc), 32'd64);
      check("init_rdy0", 32'(if0.wr_ready), 32'd1);

      acc = 1'b0;
      for (int p = 0; p < 65; p++) begin
         for (int b = 0; b < 32; b++) begin
            cnt_pixel = 7'(p); cnt_bit = 5'(b);
            #1;
            acc = acc | bit1 | bit0;
         end
      end
      check("init_all_zero", 32'(acc), 32'd0);
      cnt_pixel = '0; cnt_bit = '0;
      tick();

      // Write, commit, swap at the first boundary
      write_px(5, 24'hFF0080);
      write_px(6, 24'h00FF80);
      write_px(7, 24'h123456);
      write_px(8, 24'hA5C3E7);
      do_commit();
      check("pending_rdy1", 32'(if1.wr_ready), 32'd0);
      check("pending_rdy0", 32'(if0.wr_ready), 32'd0);
      frame_checks("f1", 1'b0, 1);
      check("clear_rdy1", 32'(if1.wr_ready), 32'd0);
      check("noclear_rdy0", 32'(if0.wr_ready), 32'd1);

      // Brightness and channel order table
      foreach (vecs[i]) begin
         bright = vecs[i].br;
         read_px(vecs[i].pix, vecs[i].exp_grb, vecs[i].exp_grb);
      end
      bright = '0;
      cnt_pixel = 7'd69; cnt_bit = 5'd8;
      @(negedge sys_clk);
      check("pix_oob_bit", 32'({bit1, bit0}), 32'd0);
      tick();
      cnt_pixel = '0;

      // Commit exactly in the boundary cycle; PENDING drops writes
      wait_ready(cyc);
      write_px(9, 24'h102030);
      frame_checks("f2", 1'b1, 0);
      check("f2_pending_rdy1", 32'(if1.wr_ready), 32'd0);
      check("f2_pending_rdy0", 32'(if0.wr_ready), 32'd0);
      write_px(10, 24'hFFFFFF);
      frame_checks("f3", 1'b0, 1);
      read_px(9, 24'h201030, 24'h201030);
      read_px(10, 24'h0, 24'h0);
      read_px(5, 24'h0, 24'h0);

      // Back bank after the swap: cleared vs. previous front contents
      wait_ready(cyc);
      do_commit();
      frame_checks("f4", 1'b0, 1);
      read_px(5, 24'h0, 24'h00FF80);
      read_px(8, 24'h0, 24'hC3A5E7);
      read_px(9, 24'h0, 24'h0);

      // Reset in the middle of CLEAR; out-of-range writes ignored
      wait_ready(cyc);
      do_commit();
      frame_checks("f5", 1'b0, 1);
      repeat (10) tick();
      check("preclr_rdy1", 32'(if1.wr_ready), 32'd0);
      cnt_pixel = 7'd6; cnt_bit = 5'd0;
      sys_rst_n = 1'b0;
      #1;
      check_reset_outs("rst2");
      check("rst2_bit", 32'({bit1, bit0}), 32'd0);
      wr_en = 1'b1; wr_addr = 7'd64; wr_rgb = 24'hFFFFFF;
      repeat (2) tick();
      sys_rst_n = 1'b1;
      cyc = 0;
      while (if1.wr_ready !== 1'b1 && cyc < 300) begin
         tick();
         cyc++;
      end
      check("reinit_cycles", 32'(cyc), 32'd64);
      repeat (3) tick();
      wr_en = 1'b0;
      write_px(1, 24'h0000FF);
      do_commit();
      frame_checks("f6", 1'b0, 1);
      read_px(0, 24'h0, 24'h0);
      read_px(1, 24'h0000FF, 24'h0000FF);
      read_px(6, 24'h0, 24'h0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
